// File: rtl/dsc_mul_rr_scheduler.sv
// dsc_mul_rr_scheduler: shares one multiplier among NUM_REQ requesters,
// round-robin accept, clear/run with watchdog, tagged response channel.
module dsc_mul_rr_scheduler #(
    parameter int DATA_WIDTH     = 5,
    parameter int NUM_INPUTS     = 2,
    parameter int WXIP1          = 1,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1100,
    localparam int IDW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [IDW-1:0]                            rsp_id,
    output logic [WXIP1-1:0]                          rsp_data,
    output logic                                      rsp_err,
    output logic                                      mul_rst,
    output logic                                      mul_en,
    output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]     mul_data_in,
    input  logic [WXIP1-1:0]                          mul_data_out,
    input  logic                                      mul_done,
    output logic                                      busy
);

    localparam int OPW = NUM_INPUTS * DATA_WIDTH;
    localparam int CW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [OPW-1:0]   ops_q, ops_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WXIP1-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mrst_q, mrst_d;

    logic             found;
    logic [IDW-1:0]   grant_idx;
    logic             accept;

    function automatic logic [IDW-1:0] wrap_add(
        input logic [IDW-1:0] base,
        input int unsigned    k
    );
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    // First asserted request at or after the pointer wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[wrap_add(ptr_q, k)]) begin
                found     = 1'b1;
                grant_idx = wrap_add(ptr_q, k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ops_d   = ops_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CLR;
                    ptr_d   = wrap_add(grant_idx, 1);
                    ops_d   = req_data[32'(grant_idx) * OPW +: OPW];
                    id_d    = grant_idx;
                end
            end
            S_CLR: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: begin
                // done takes priority over a coincident terminal count
                if (mul_done) begin
                    state_d = S_RESP;
                    data_d  = mul_data_out;
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_RESP;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mrst_d = (state_d == S_CLR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            ops_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            mrst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ops_q   <= ops_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            mrst_q  <= mrst_d;
        end
    end

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = id_q;
    assign rsp_data    = data_q;
    assign rsp_err     = err_q;
    assign mul_rst     = mrst_q;
    assign mul_en      = (state_q == S_RUN);
    assign mul_data_in = ops_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_dsc_mul_rr_scheduler.sv
// Bench for dsc_mul_rr_scheduler: requester-level model feeds a scoreboard,
// a latency-programmable multiplier stub answers the shared port.
module tb_dsc_mul_rr_scheduler;

    localparam int DW  = 5;
    localparam int NI  = 2;
    localparam int WX  = 1;
    localparam int NR  = 4;
    localparam int TO  = 16;
    localparam int IDW = 2;
    localparam int OPW = NI * DW;

    typedef struct {
        int id;
        int data;
        int err;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR*OPW-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [WX-1:0] rsp_data;
    logic rsp_err;
    logic mul_rst;
    logic mul_en;
    logic [NI-1:0][DW-1:0] mul_data_in;
    logic [WX-1:0] mul_data_out;
    logic mul_done;
    logic busy;

    logic [OPW-1:0] ops [NR];
    int lat_tab [NR];
    logic [WX-1:0] out_tab [NR];
    int cur_lat = 1;
    logic [WX-1:0] cur_out = '0;
    logic [OPW-1:0] cur_ops = '0;
    logic [7:0] scnt = '0;
    logic spur = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    int last_hs = -10;
    int last_g = 0;
    int ptr_m = 0;
    int clr_ph = 0;
    int g_m;
    bit idle_m;
    bit pv = 1'b0;
    exp_t e_m;
    exp_t exp_q [$];
    int before_acc;
    int n;
    int lats [4];

    dsc_mul_rr_scheduler #(
        .DATA_WIDTH(DW),
        .NUM_INPUTS(NI),
        .WXIP1(WX),
        .NUM_REQ(NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .mul_rst(mul_rst),
        .mul_en(mul_en),
        .mul_data_in(mul_data_in),
        .mul_data_out(mul_data_out),
        .mul_done(mul_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_data = '0;
        for (int r = 0; r < NR; r++) begin
            req_data[r*OPW +: OPW] = ops[r];
        end
    end

    // Multiplier stub: done in the cur_lat-th enabled cycle after a clear.
    always @(posedge clk) begin
        if (mul_rst) scnt <= '0;
        else if (mul_en) scnt <= scnt + 8'd1;
    end

    assign mul_done = (mul_en && cur_lat != 0 && int'(scnt) == cur_lat - 1)
                    || (spur && !mul_en);
    assign mul_data_out = cur_out;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int winner(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // Request side: model arbitration and push the expected response.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            ptr_m = 0;
            exp_q.delete();
            clr_ph = 0;
            acc_cnt = rsp_cnt;
        end else begin
            if (clr_ph == 2) begin
                chk("run_mul_rst", int'(mul_rst), 0);
                chk("run_mul_en", int'(mul_en), 1);
                clr_ph = 0;
            end
            if (clr_ph == 1) begin
                chk("clr_mul_rst", int'(mul_rst), 1);
                chk("clr_mul_en", int'(mul_en), 0);
                chk("clr_operands", int'(mul_data_in), int'(cur_ops));
                chk("clr_busy", int'(busy), 1);
                clr_ph = 2;
            end
            idle_m = (exp_q.size() == 0) && (cyc != last_hs);
            g_m = winner(req_valid, ptr_m);
            if (idle_m) chk("req_ready", int'(req_ready), (g_m < 0) ? 0 : (1 << g_m));
            else chk("req_ready_busy", int'(req_ready), 0);
            if ((req_valid & req_ready) != 0 && idle_m && g_m >= 0) begin
                cur_lat = lat_tab[g_m];
                cur_out = out_tab[g_m];
                cur_ops = ops[g_m];
                e_m.id = g_m;
                if (cur_lat != 0 && cur_lat <= TO) begin
                    e_m.data = int'(cur_out);
                    e_m.err = 0;
                    e_m.cyc = cyc + 2 + cur_lat;
                end else begin
                    e_m.data = 0;
                    e_m.err = 1;
                    e_m.cyc = cyc + 2 + TO;
                end
                exp_q.push_back(e_m);
                ptr_m = (g_m + 1) % NR;
                last_g = g_m;
                acc_cnt++;
                clr_ph = 1;
            end
        end
    end

    // Response side: pop and compare whenever a response is presented.
    always @(negedge clk) begin
        if (!rst) begin
            pv = 1'b0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_pending", 0, 1);
            end else begin
                if (!pv) chk("rsp_cycle", cyc, exp_q[0].cyc);
                chk("rsp_id", int'(rsp_id), exp_q[0].id);
                chk("rsp_data", int'(rsp_data), exp_q[0].data);
                chk("rsp_err", int'(rsp_err), exp_q[0].err);
            end
            chk("rsp_mul_en", int'(mul_en), 0);
            chk("rsp_busy", int'(busy), 1);
            if (rsp_ready) begin
                pv = 1'b0;
                if (exp_q.size() != 0) exp_q.delete(0);
                last_hs = cyc;
                rsp_cnt++;
            end else begin
                pv = 1'b1;
            end
        end else begin
            if (pv) chk("rsp_dropped", int'(rsp_valid), 1);
            pv = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input bit drop);
        int start;
        int k;
        start = acc_cnt;
        k = 0;
        while (acc_cnt == start && k < 500) begin
            tick();
            k++;
        end
        chk("accept_seen", acc_cnt - start, 1);
        if (drop && acc_cnt != start) req_valid[last_g] = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (rsp_cnt != acc_cnt && k < 500) begin
            tick();
            k++;
        end
        chk("drain", rsp_cnt, acc_cnt);
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            ops[r] = '0;
            lat_tab[r] = 1;
            out_tab[r] = '0;
        end
        #1 rst = 1'b0;
        #2;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_mul_en", int'(mul_en), 0);
        chk("rst_mul_rst", int'(mul_rst), 1);
        chk("rst_mul_data_in", int'(mul_data_in), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        tick();
        chk("mul_rst_fall", int'(mul_rst), 0);

        // single requester, operands 12 and 20
        rsp_ready = 1'b1;
        ops[2] = {5'd20, 5'd12};
        lat_tab[2] = 8;
        out_tab[2] = 1'b1;
        req_valid = 4'b0100;
        wait_accept(1'b1);
        wait_drain();

        // all requesters continuously valid
        for (int r = 0; r < NR; r++) begin
            ops[r] = OPW'($urandom);
            lat_tab[r] = int'($urandom_range(1, 6));
            out_tab[r] = WX'($urandom);
        end
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            wait_accept(1'b0);
            ops[last_g] = OPW'($urandom);
        end
        req_valid = '0;
        wait_drain();

        // pointer wrap and skip
        req_valid = 4'b1000;
        wait_accept(1'b1);
        wait_drain();
        req_valid = 4'b0110;
        wait_accept(1'b1);
        wait_accept(1'b1);
        wait_drain();

        // response backpressure with a waiting requester
        rsp_ready = 1'b0;
        lat_tab[0] = 3;
        req_valid = 4'b0001;
        wait_accept(1'b1);
        req_valid = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 500) begin
            tick();
            n++;
        end
        chk("bp_rsp_seen", int'(rsp_valid), 1);
        repeat (5) tick();
        rsp_ready = 1'b1;
        wait_accept(1'b1);
        wait_drain();

        // watchdog: never done, coincident, just before, just after
        lats = '{0, TO, TO - 1, TO + 1};
        for (int i = 0; i < 4; i++) begin
            lat_tab[1] = lats[i];
            out_tab[1] = 1'b1;
            req_valid = 4'b0010;
            wait_accept(1'b1);
            wait_drain();
        end

        // random traffic, backpressure, withdrawals, stray done pulses
        for (int c = 0; c < 400; c++) begin
            before_acc = acc_cnt;
            tick();
            if (acc_cnt != before_acc) req_valid[last_g] = 1'b0;
            rsp_ready = ($urandom_range(0, 3) != 0);
            spur = ($urandom_range(0, 7) == 0);
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r] && $urandom_range(0, 3) == 0) begin
                    ops[r] = OPW'($urandom);
                    lat_tab[r] = int'($urandom_range(0, 18));
                    out_tab[r] = WX'($urandom);
                    req_valid[r] = 1'b1;
                end else if (req_valid[r] && $urandom_range(0, 15) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
        end
        req_valid = '0;
        spur = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();

        // reset during the fourth RUN cycle
        lat_tab[2] = 0;
        req_valid = 4'b0100;
        wait_accept(1'b1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_req_ready", int'(req_ready), 0);
        chk("mid_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rsp_id", int'(rsp_id), 0);
        chk("mid_rsp_data", int'(rsp_data), 0);
        chk("mid_rsp_err", int'(rsp_err), 0);
        chk("mid_mul_en", int'(mul_en), 0);
        chk("mid_mul_rst", int'(mul_rst), 1);
        chk("mid_mul_data_in", int'(mul_data_in), 0);
        chk("mid_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int r = 0; r < NR; r++) lat_tab[r] = 4;
        req_valid = '1;
        wait_accept(1'b0);
        req_valid = '0;
        wait_drain();
        repeat (3) tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
